// File: rtl/huffman_symbol_sequencer.sv
// Turns zigzag-ordered quantised blocks into a stream of DC-difference and
// (run, size, amplitude) AC symbols for a downstream Huffman table stage.
module huffman_symbol_sequencer #(
    parameter int unsigned COEF_W   = 8,
    parameter int unsigned NUM_COMP = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  blk_valid,
    output logic                  blk_ready,
    input  logic [64*COEF_W-1:0]  blk_coefs,
    input  logic [1:0]            blk_comp,
    input  logic                  restart,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_is_dc,
    output logic [3:0]            out_run,
    output logic [4:0]            out_size,
    output logic [COEF_W:0]       out_amp,
    output logic [1:0]            out_comp,
    output logic                  out_last,
    output logic                  busy,
    output logic                  comp_err
);

    localparam int unsigned DW       = COEF_W + 1;
    localparam int unsigned NUM_COEF = 64;

    typedef enum logic [1:0] {IDLE, DC, SCAN, DONE} state_t;

    // Bit length of |v|; v never reaches the most negative DW-bit value.
    function automatic logic [4:0] size_of(input logic [DW-1:0] v);
        logic [DW-1:0] mag;
        size_of = '0;
        mag = v[DW-1] ? DW'(~v + 1'b1) : v;
        for (int i = 0; i < int'(DW); i++) begin
            if (mag[i]) size_of = 5'(i + 1);
        end
    endfunction

    // Negative values are sent as (v-1) truncated to size bits.
    function automatic logic [DW-1:0] amp_of(input logic [DW-1:0] v, input logic [4:0] size);
        logic [DW-1:0] base;
        logic [DW-1:0] mask;
        base   = v[DW-1] ? DW'(v - 1'b1) : v;
        mask   = ~({DW{1'b1}} << size);
        amp_of = base & mask;
    endfunction

    state_t            state_q, state_d;
    logic [5:0]        idx_q, idx_d;
    logic [3:0]        run_q, run_d;
    logic [5:0]        last_nz_q, last_nz_c;
    logic [COEF_W-1:0] coef_q [NUM_COEF];
    logic [COEF_W-1:0] pred_q [4];

    logic              accept_c, comp_ok_c, slot_free_c, ld_c, clr_c;
    logic [1:0]        pidx_c;
    logic [COEF_W-1:0] pred_sel_c, dc_c, cur_c;
    logic [DW-1:0]     val_c, val_amp_c, sym_amp_c;
    logic [4:0]        val_size_c, sym_size_c;
    logic [3:0]        sym_run_c;
    logic              sym_dc_c, sym_last_c;

    assign accept_c    = (state_q == IDLE) && blk_valid;
    assign comp_ok_c   = 32'(blk_comp) < NUM_COMP;
    assign pidx_c      = comp_ok_c ? blk_comp : 2'd0;
    assign pred_sel_c  = restart ? '0 : pred_q[pidx_c];
    assign dc_c        = blk_coefs[COEF_W-1:0];
    assign cur_c       = coef_q[idx_q];
    assign slot_free_c = !out_valid || out_ready;

    // One shared size/amplitude datapath: DC difference in IDLE, current AC otherwise.
    assign val_c      = (state_q == IDLE)
                      ? DW'({dc_c[COEF_W-1], dc_c} - {pred_sel_c[COEF_W-1], pred_sel_c})
                      : {cur_c[COEF_W-1], cur_c};
    assign val_size_c = size_of(val_c);
    assign val_amp_c  = amp_of(val_c, val_size_c);

    always_comb begin
        last_nz_c = '0;
        for (int k = 1; k < int'(NUM_COEF); k++) begin
            if (blk_coefs[k*COEF_W +: COEF_W] != '0) last_nz_c = 6'(k);
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        run_d      = run_q;
        ld_c       = 1'b0;
        clr_c      = 1'b0;
        sym_dc_c   = 1'b0;
        sym_run_c  = '0;
        sym_size_c = '0;
        sym_amp_c  = '0;
        sym_last_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    ld_c       = 1'b1;
                    sym_dc_c   = 1'b1;
                    sym_size_c = val_size_c;
                    sym_amp_c  = val_amp_c;
                    state_d    = DC;
                end
            end
            DC: begin
                if (slot_free_c) begin
                    if (last_nz_q == '0) begin
                        ld_c       = 1'b1;
                        sym_last_c = 1'b1;
                        state_d    = DONE;
                    end else begin
                        clr_c   = 1'b1;
                        idx_d   = 6'd1;
                        run_d   = '0;
                        state_d = SCAN;
                    end
                end
            end
            SCAN: begin
                if (slot_free_c) begin
                    if (idx_q > last_nz_q) begin
                        ld_c       = 1'b1;
                        sym_last_c = 1'b1;
                        state_d    = DONE;
                    end else if (cur_c == '0) begin
                        idx_d = 6'(idx_q + 1'b1);
                        if (run_q != 4'd15) begin
                            clr_c = 1'b1;
                            run_d = 4'(run_q + 1'b1);
                        end else begin
                            ld_c      = 1'b1;
                            sym_run_c = 4'd15;
                            run_d     = '0;
                        end
                    end else begin
                        ld_c       = 1'b1;
                        sym_run_c  = run_q;
                        sym_size_c = val_size_c;
                        sym_amp_c  = val_amp_c;
                        sym_last_c = (idx_q == 6'd63);
                        run_d      = '0;
                        idx_d      = 6'(idx_q + 1'b1);
                        if (idx_q == 6'd63) state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_valid && out_ready) begin
                    clr_c   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            run_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            run_q   <= run_d;
        end
    end

    // Coefficient store carries no state meaningful across reset.
    always_ff @(posedge clock) begin
        if (accept_c) begin
            for (int k = 0; k < int'(NUM_COEF); k++) begin
                coef_q[k] <= blk_coefs[k*COEF_W +: COEF_W];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_nz_q <= '0;
            out_valid <= 1'b0;
            out_is_dc <= 1'b0;
            out_run   <= '0;
            out_size  <= '0;
            out_amp   <= '0;
            out_comp  <= '0;
            out_last  <= 1'b0;
            blk_ready <= 1'b1;
            busy      <= 1'b0;
            comp_err  <= 1'b0;
            for (int c = 0; c < 4; c++) pred_q[c] <= '0;
        end else begin
            blk_ready <= (state_d == IDLE);
            busy      <= (state_d != IDLE);
            if (ld_c) begin
                out_valid <= 1'b1;
                out_is_dc <= sym_dc_c;
                out_run   <= sym_run_c;
                out_size  <= sym_size_c;
                out_amp   <= sym_amp_c;
                out_last  <= sym_last_c;
            end else if (clr_c) begin
                out_valid <= 1'b0;
            end
            // Restart clears first so a coinciding acceptance still records its DC.
            if ((state_q == IDLE) && restart) begin
                for (int c = 0; c < 4; c++) pred_q[c] <= '0;
                comp_err <= 1'b0;
            end
            if (accept_c) begin
                last_nz_q <= last_nz_c;
                out_comp  <= blk_comp;
                if (comp_ok_c) pred_q[blk_comp] <= dc_c;
                else           comp_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_huffman_symbol_sequencer.sv
// Directed bench for huffman_symbol_sequencer: hand-computed symbol streams
// for DC prediction, AC run/size coding, ZRL/EOB, stalls, restart and reset.
module tb_huffman_symbol_sequencer;

    localparam int unsigned COEF_W = 8;

    logic                  clock = 1'b0;
    logic                  reset;
    logic                  blk_valid;
    logic                  blk_ready;
    logic [64*COEF_W-1:0]  blk_coefs;
    logic [1:0]            blk_comp;
    logic                  restart;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_is_dc;
    logic [3:0]            out_run;
    logic [4:0]            out_size;
    logic [COEF_W:0]       out_amp;
    logic [1:0]            out_comp;
    logic                  out_last;
    logic                  busy;
    logic                  comp_err;

    int n_assert = 0;
    int n_fail   = 0;
    logic [64*COEF_W-1:0] cf;
    logic [3:0]           snap_run;
    logic [4:0]           snap_size;
    logic [COEF_W:0]      snap_amp;

    huffman_symbol_sequencer #(.COEF_W(COEF_W), .NUM_COMP(3)) dut (
        .clock(clock), .reset(reset), .blk_valid(blk_valid), .blk_ready(blk_ready),
        .blk_coefs(blk_coefs), .blk_comp(blk_comp), .restart(restart),
        .out_valid(out_valid), .out_ready(out_ready), .out_is_dc(out_is_dc),
        .out_run(out_run), .out_size(out_size), .out_amp(out_amp), .out_comp(out_comp),
        .out_last(out_last), .busy(busy), .comp_err(comp_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic new_block(input int dc);
        cf = '0;
        cf[COEF_W-1:0] = 8'(dc);
    endtask

    task automatic set_ac(input int k, input int v);
        cf[k*COEF_W +: COEF_W] = 8'(v);
    endtask

    // Offers cf at a negedge; returns at the negedge after acceptance.
    task automatic send_block(input string tag, input logic [1:0] comp, input logic rs);
        int n = 0;
        while (!blk_ready && n < 200) begin @(negedge clock); n++; end
        chk({tag, ".ready"}, 32'(blk_ready), 1);
        blk_coefs = cf;
        blk_comp  = comp;
        restart   = rs;
        blk_valid = 1'b1;
        @(negedge clock);
        blk_valid = 1'b0;
        restart   = 1'b0;
        chk({tag, ".busy"}, 32'(busy), 1);
    endtask

    // Waits (bounded) for a symbol, checks it, returns one negedge later.
    task automatic expect_sym(input string tag, input logic dc, input int run, input int size,
                              input int amp, input logic last, input logic [1:0] comp);
        int n = 0;
        while (!out_valid && n < 200) begin @(negedge clock); n++; end
        chk({tag, ".valid"}, 32'(out_valid), 1);
        chk({tag, ".is_dc"}, 32'(out_is_dc), 32'(dc));
        chk({tag, ".run"},   32'(out_run),   run);
        chk({tag, ".size"},  32'(out_size),  size);
        chk({tag, ".amp"},   32'(out_amp),   amp);
        chk({tag, ".last"},  32'(out_last),  32'(last));
        chk({tag, ".comp"},  32'(out_comp),  32'(comp));
        @(negedge clock);
    endtask

    task automatic expect_idle(input string tag);
        chk({tag, ".out_valid"}, 32'(out_valid), 0);
        chk({tag, ".blk_ready"}, 32'(blk_ready), 1);
        chk({tag, ".busy"},      32'(busy),      0);
    endtask

    initial begin
        reset     = 1'b1;
        blk_valid = 1'b0;
        blk_coefs = '0;
        blk_comp  = '0;
        restart   = 1'b0;
        out_ready = 1'b1;
        cf        = '0;
        repeat (3) @(negedge clock);
        expect_idle("rst");
        chk("rst.comp_err", 32'(comp_err), 0);
        chk("rst.size",     32'(out_size), 0);
        reset = 1'b0;
        @(negedge clock);

        // comp0 DC=+5, no AC
        new_block(5);
        send_block("t1", 2'd0, 1'b0);
        expect_sym("t1.dc",  1'b1, 0, 3, 5, 1'b0, 2'd0);
        expect_sym("t1.eob", 1'b0, 0, 0, 0, 1'b1, 2'd0);
        expect_idle("t1.end");

        // comp0 DC=+2 -> diff -3
        new_block(2);
        send_block("t2", 2'd0, 1'b0);
        expect_sym("t2.dc",  1'b1, 0, 2, 0, 1'b0, 2'd0);
        expect_sym("t2.eob", 1'b0, 0, 0, 0, 1'b1, 2'd0);
        expect_idle("t2.end");

        // comp1 has its own predictor
        new_block(2);
        send_block("t3", 2'd1, 1'b0);
        expect_sym("t3.dc",  1'b1, 0, 2, 2, 1'b0, 2'd1);
        expect_sym("t3.eob", 1'b0, 0, 0, 0, 1'b1, 2'd1);

        // k1=-1, k20=3: 18 zeros in between give a ZRL then run 2
        new_block(2); set_ac(1, -1); set_ac(20, 3);
        send_block("t4", 2'd1, 1'b0);
        expect_sym("t4.dc",  1'b1, 0,  0, 0, 1'b0, 2'd1);
        expect_sym("t4.k1",  1'b0, 0,  1, 0, 1'b0, 2'd1);
        expect_sym("t4.zrl", 1'b0, 15, 0, 0, 1'b0, 2'd1);
        expect_sym("t4.k20", 1'b0, 2,  2, 3, 1'b0, 2'd1);
        expect_sym("t4.eob", 1'b0, 0,  0, 0, 1'b1, 2'd1);
        expect_idle("t4.end");

        // only k63 nonzero: 3 ZRL then last symbol, no EOB
        new_block(2); set_ac(63, 1);
        send_block("t5", 2'd0, 1'b0);
        expect_sym("t5.dc",   1'b1, 0,  0, 0, 1'b0, 2'd0);
        expect_sym("t5.zrl0", 1'b0, 15, 0, 0, 1'b0, 2'd0);
        expect_sym("t5.zrl1", 1'b0, 15, 0, 0, 1'b0, 2'd0);
        expect_sym("t5.zrl2", 1'b0, 15, 0, 0, 1'b0, 2'd0);
        expect_sym("t5.k63",  1'b0, 14, 1, 1, 1'b1, 2'd0);
        expect_idle("t5.end");

        // downstream stall of 5 cycles on the k1 symbol
        new_block(7); set_ac(1, -1); set_ac(20, 3);
        send_block("t6", 2'd2, 1'b0);
        expect_sym("t6.dc", 1'b1, 0, 3, 7, 1'b0, 2'd2);
        for (int n = 0; n < 200 && !out_valid; n++) @(negedge clock);
        out_ready = 1'b0;
        snap_run  = out_run;
        snap_size = out_size;
        snap_amp  = out_amp;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("t6.stall.valid", 32'(out_valid), 1);
            chk("t6.stall.run",   32'(out_run),   32'(snap_run));
            chk("t6.stall.size",  32'(out_size),  32'(snap_size));
            chk("t6.stall.amp",   32'(out_amp),   32'(snap_amp));
            chk("t6.stall.ready", 32'(blk_ready), 0);
        end
        out_ready = 1'b1;
        expect_sym("t6.k1",  1'b0, 0,  1, 0, 1'b0, 2'd2);
        expect_sym("t6.zrl", 1'b0, 15, 0, 0, 1'b0, 2'd2);
        expect_sym("t6.k20", 1'b0, 2,  2, 3, 1'b0, 2'd2);
        expect_sym("t6.eob", 1'b0, 0,  0, 0, 1'b1, 2'd2);
        expect_idle("t6.end");

        // comp 3 is out of range: predictor 0 (=2) used, not updated
        new_block(1);
        send_block("t7", 2'd3, 1'b0);
        expect_sym("t7.dc",  1'b1, 0, 1, 0, 1'b0, 2'd3);
        expect_sym("t7.eob", 1'b0, 0, 0, 0, 1'b1, 2'd3);
        chk("t7.comp_err", 32'(comp_err), 1);

        // restart together with acceptance: diff uses 0, comp_err cleared
        new_block(3);
        send_block("t8", 2'd0, 1'b1);
        chk("t8.comp_err", 32'(comp_err), 0);
        expect_sym("t8.dc",  1'b1, 0, 2, 3, 1'b0, 2'd0);
        expect_sym("t8.eob", 1'b0, 0, 0, 0, 1'b1, 2'd0);

        // comp2 predictor was cleared by the restart
        new_block(7);
        send_block("t9", 2'd2, 1'b0);
        expect_sym("t9.dc",  1'b1, 0, 3, 7, 1'b0, 2'd2);
        expect_sym("t9.eob", 1'b0, 0, 0, 0, 1'b1, 2'd2);

        // reset while a ZRL is held mid-scan
        new_block(3); set_ac(63, 1);
        send_block("t10", 2'd0, 1'b0);
        expect_sym("t10.dc", 1'b1, 0, 0, 0, 1'b0, 2'd0);
        for (int n = 0; n < 200 && !out_valid; n++) @(negedge clock);
        chk("t10.zrl.run", 32'(out_run), 15);
        out_ready = 1'b0;
        reset     = 1'b1;
        @(posedge clock);
        #1;
        chk("t10.rst.valid", 32'(out_valid), 0);
        chk("t10.rst.run",   32'(out_run),   0);
        @(negedge clock);
        reset     = 1'b0;
        out_ready = 1'b1;
        expect_idle("t10.rst");

        // predictor 0 cleared by reset
        new_block(4);
        send_block("t11", 2'd0, 1'b0);
        expect_sym("t11.dc",  1'b1, 0, 3, 4, 1'b0, 2'd0);
        expect_sym("t11.eob", 1'b0, 0, 0, 0, 1'b1, 2'd0);

        // most negative DC: diff -128 -> size 8, amp 0x7F
        new_block(-128);
        send_block("t12", 2'd1, 1'b0);
        expect_sym("t12.dc",  1'b1, 0, 8, 127, 1'b0, 2'd1);
        expect_sym("t12.eob", 1'b0, 0, 0, 0,   1'b1, 2'd1);
        expect_idle("t12.end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
